alu_exec_stage: RTL and testbench

//  Single-cycle MIPS execute stage: ALU-control decode, ALU operand-B mux and 32-bit ALU.

---
 rtl/alu_exec_stage.sv | 126 ++++++++++++
 tb/tb_alu_exec_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// MIPS execute stage: ALU-control decode, operand-B select and WIDTH-bit ALU,
// with a one-cycle registered copy of the result for debug and timing paths.
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic             alu_src,
  input  logic [WIDTH-1:0] read_data1,
  input  logic [WIDTH-1:0] read_data2,
  input  logic [WIDTH-1:0] sign_imm,
  output logic [3:0]       alu_operation,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic [WIDTH-1:0] result_q,
  output logic             zero_q,
  output logic             valid_q
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_BAD = 4'b1111;

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] and_bits;
  logic [WIDTH-1:0] or_bits;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             sub_ovf;
  logic             less;

  // funct is only examined for R-type, so X on it elsewhere never propagates
  always_comb begin
    alu_operation = OP_BAD;
    illegal       = 1'b0;
    case (alu_op)
      2'b00: alu_operation = OP_ADD;
      2'b01: alu_operation = OP_SUB;
      2'b11: alu_operation = OP_OR;
      default: begin
        case (funct)
          6'b100000: alu_operation = OP_ADD;
          6'b100010: alu_operation = OP_SUB;
          6'b100100: alu_operation = OP_AND;
          6'b100101: alu_operation = OP_OR;
          6'b100111: alu_operation = OP_NOR;
          6'b101010: alu_operation = OP_SLT;
          default: begin
            alu_operation = OP_BAD;
            illegal       = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign operand_a = read_data1;
  assign operand_b = alu_src ? sign_imm : read_data2;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
      assign and_bits[gi] = operand_a[gi] & operand_b[gi];
      assign or_bits[gi]  = operand_a[gi] | operand_b[gi];
    end
  endgenerate

  assign sum  = operand_a + operand_b;
  assign diff = operand_a - operand_b;

  assign add_ovf = (operand_a[MSB] == operand_b[MSB]) && (sum[MSB] != operand_a[MSB]);
  assign sub_ovf = (operand_a[MSB] != operand_b[MSB]) && (diff[MSB] != operand_a[MSB]);

  // Differing signs decide slt directly, so a wrapped difference cannot mislead it
  assign less = (operand_a[MSB] != operand_b[MSB]) ? operand_a[MSB] : diff[MSB];

  always_comb begin
    alu_result = '0;
    overflow   = 1'b0;
    case (alu_operation)
      OP_AND: alu_result = and_bits;
      OP_OR:  alu_result = or_bits;
      OP_ADD: begin
        alu_result = sum;
        overflow   = add_ovf;
      end
      OP_SUB: begin
        alu_result = diff;
        overflow   = sub_ovf;
      end
      OP_SLT: alu_result = {{(WIDTH-1){1'b0}}, less};
      OP_NOR: alu_result = ~or_bits;
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        result_q <= alu_result;
        zero_q   <= zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic        alu_src;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] sign_imm;
  logic [3:0]  alu_operation;
  logic [31:0] alu_result;
  logic        zero;
  logic        overflow;
  logic        illegal;
  logic [31:0] result_q;
  logic        zero_q;
  logic        valid_q;

  int total  = 0;
  int passed = 0;

  logic [31:0] exp_rq;
  logic        exp_zq;
  logic        exp_vq;

  localparam longint MAX_S = 64'sd2147483647;
  localparam longint MIN_S = -64'sd2147483648;

  alu_exec_stage #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .alu_op(alu_op),
    .funct(funct),
    .alu_src(alu_src),
    .read_data1(read_data1),
    .read_data2(read_data2),
    .sign_imm(sign_imm),
    .alu_operation(alu_operation),
    .alu_result(alu_result),
    .zero(zero),
    .overflow(overflow),
    .illegal(illegal),
    .result_q(result_q),
    .zero_q(zero_q),
    .valid_q(valid_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
    end
  endtask

  // Reference: instruction-level meaning with signed 64-bit arithmetic
  function automatic void model(input logic [1:0] op, input logic [5:0] f, input logic src,
                                input logic [31:0] a, input logic [31:0] rd2, input logic [31:0] imm,
                                output logic [3:0] eop, output logic [31:0] er,
                                output logic ez, output logic eovf, output logic eill);
    logic [31:0] b;
    longint sa, sb, s;
    b    = src ? imm : rd2;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    eill = 1'b0;
    eovf = 1'b0;
    case (op)
      2'd0: eop = 4'b0010;
      2'd1: eop = 4'b0110;
      2'd3: eop = 4'b0001;
      default: begin
        case (f)
          6'd32: eop = 4'b0010;
          6'd34: eop = 4'b0110;
          6'd36: eop = 4'b0000;
          6'd37: eop = 4'b0001;
          6'd39: eop = 4'b1100;
          6'd42: eop = 4'b0111;
          default: begin
            eop  = 4'b1111;
            eill = 1'b1;
          end
        endcase
      end
    endcase
    case (eop)
      4'b0000: er = a & b;
      4'b0001: er = a | b;
      4'b0010: begin
        s    = sa + sb;
        er   = s[31:0];
        eovf = (s > MAX_S) || (s < MIN_S);
      end
      4'b0110: begin
        s    = sa - sb;
        er   = s[31:0];
        eovf = (s > MAX_S) || (s < MIN_S);
      end
      4'b0111: er = (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: er = ~(a | b);
      default: er = 32'd0;
    endcase
    ez = (er == 32'd0);
  endfunction

  task automatic apply(input logic [1:0] op, input logic [5:0] f, input logic src,
                       input logic [31:0] a, input logic [31:0] rd2, input logic [31:0] imm,
                       input logic v);
    logic [3:0]  eop;
    logic [31:0] er;
    logic        ez, eovf, eill;
    @(negedge clk);
    alu_op     = op;
    funct      = f;
    alu_src    = src;
    read_data1 = a;
    read_data2 = rd2;
    sign_imm   = imm;
    in_valid   = v;
    #1;
    model(op, f, src, a, rd2, imm, eop, er, ez, eovf, eill);
    $display("txn op=%0d funct=%02h src=%0d a=%08h b2=%08h imm=%08h v=%0d -> op=%04b res=%08h",
             op, f, src, a, rd2, imm, v, alu_operation, alu_result);
    check("alu_operation", {28'd0, alu_operation}, {28'd0, eop});
    check("alu_result", alu_result, er);
    check("zero", {31'd0, zero}, {31'd0, ez});
    check("overflow", {31'd0, overflow}, {31'd0, eovf});
    check("illegal", {31'd0, illegal}, {31'd0, eill});
    if (v) begin
      exp_rq = er;
      exp_zq = ez;
    end
    exp_vq = v;
    @(posedge clk);
    #1;
    check("result_q", result_q, exp_rq);
    check("zero_q", {31'd0, zero_q}, {31'd0, exp_zq});
    check("valid_q", {31'd0, valid_q}, {31'd0, exp_vq});
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0] legal [6];
    logic [5:0] f;
    legal[0] = 6'b100000; legal[1] = 6'b100010; legal[2] = 6'b100100;
    legal[3] = 6'b100101; legal[4] = 6'b100111; legal[5] = 6'b101010;

    reset = 1'b1; in_valid = 1'b0; alu_op = 2'b00; funct = 6'd0; alu_src = 1'b0;
    read_data1 = '0; read_data2 = '0; sign_imm = '0;
    exp_rq = '0; exp_zq = 1'b0; exp_vq = 1'b0;
    #2;
    check("reset result_q", result_q, 32'd0);
    check("reset zero_q", {31'd0, zero_q}, 32'd0);
    check("reset valid_q", {31'd0, valid_q}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases
    apply(2'b00, 6'd0, 1'b1, 32'd100, 32'd0, 32'hFFFF_FFFC, 1'b1);
    apply(2'b01, 6'd0, 1'b0, 32'h1234, 32'h1234, 32'd7, 1'b1);
    apply(2'b10, 6'b101010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    apply(2'b10, 6'b101010, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 1'b1);
    apply(2'b10, 6'b100000, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 1'b1);
    apply(2'b10, 6'b100111, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    apply(2'b10, 6'b000000, 1'b0, 32'h55, 32'h66, 32'd0, 1'b1);
    apply(2'b11, 6'd0, 1'b1, 32'hF0, 32'd0, 32'h0F, 1'b1);
    apply(2'b10, 6'b100010, 1'b0, 32'h8000_0000, 32'd1, 32'd0, 1'b1);
    // Hold: an invalid cycle must not disturb result_q/zero_q
    apply(2'b00, 6'd0, 1'b0, 32'd5, 32'd6, 32'd0, 1'b0);
    apply(2'b01, 6'd0, 1'b0, 32'd9, 32'd9, 32'd0, 1'b0);

    // Mid-run asynchronous reset, asserted away from any clock edge
    apply(2'b11, 6'd0, 1'b0, 32'hA5, 32'h5A00, 32'd0, 1'b1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async result_q", result_q, 32'd0);
    check("async zero_q", {31'd0, zero_q}, 32'd0);
    check("async valid_q", {31'd0, valid_q}, 32'd0);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("held result_q", result_q, 32'd0);
    check("held valid_q", {31'd0, valid_q}, 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    exp_rq = '0; exp_zq = 1'b0; exp_vq = 1'b0;
    apply(2'b00, 6'd0, 1'b0, 32'd3, 32'd4, 32'd0, 1'b1);

    // Randomized operations
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0) f = legal[$urandom_range(0, 5)];
      else f = 6'($urandom);
      apply(2'($urandom), f, 1'($urandom), rnd_val(), rnd_val(), rnd_val(),
            ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
